// File: rtl/uart_term_bridge.sv
// UART RX stream -> LCD text controller bridge: buffers bytes, classifies them into
// putchar/clearhome pulses paced by the controller's busy flag, and optionally echoes them.
module uart_term_bridge #(
  parameter int          FIFO_DEPTH = 16,
  parameter bit          ECHO_EN    = 1'b1,
  parameter logic [7:0]  CLEAR_CHAR = 8'h0C,
  parameter int          GUARD      = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [7:0]                      s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [7:0]                      m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  input  logic                            i_flush,
  input  logic                            i_busy,
  output logic                            o_putchar,
  output logic                            o_clearhome,
  output logic [7:0]                      o_char,
  output logic [$clog2(FIFO_DEPTH):0]     o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GUARD + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD_WAIT, BUSY_WAIT} state_t;
  typedef enum logic [1:0] {CLS_DROP, CLS_PUT, CLS_CLR} cls_t;

  state_t         state, state_nx;
  logic [LW-1:0]  wptr, rptr;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [7:0]     head;
  logic [GW-1:0]  gcnt;
  logic           rdy_en;
  logic           full, empty, echo_ok, wr, pop;
  logic           put_d, clr_d;
  cls_t           cls;

  function automatic cls_t classify(input logic [7:0] b);
    if (b == CLEAR_CHAR)                                    return CLS_CLR;
    if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 ||
        b == 8'h0A || b == 8'h0D)                           return CLS_PUT;
    return CLS_DROP;
  endfunction

  // Keeps tready low for the first cycle after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;

  assign o_level       = wptr - rptr;
  assign full          = (o_level == LW'(FIFO_DEPTH));
  assign empty         = (wptr == rptr);
  assign echo_ok       = !ECHO_EN || !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = rdy_en && !full && !i_flush && echo_ok;
  assign wr            = s_axis_tvalid && s_axis_tready;
  assign pop           = (state == IDLE) && !empty && !i_busy && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (i_flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr)  wptr <= wptr + LW'(1);
      if (pop) rptr <= rptr + LW'(1);
    end

  always_ff @(posedge i_clk)
    if (wr) mem[wptr[AW-1:0]] <= s_axis_tdata;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)  head <= '0;
    else if (pop)  head <= mem[rptr[AW-1:0]];

  generate
    if (ECHO_EN) begin : g_echo
      logic [7:0] echo_data;
      logic       echo_vld;
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
          echo_data <= '0;
          echo_vld  <= 1'b0;
        end else if (wr) begin
          echo_data <= s_axis_tdata;
          echo_vld  <= 1'b1;
        end else if (echo_vld && m_axis_tready) begin
          echo_vld  <= 1'b0;
        end
      assign m_axis_tdata  = echo_data;
      assign m_axis_tvalid = echo_vld;
    end else begin : g_no_echo
      assign m_axis_tdata  = '0;
      assign m_axis_tvalid = 1'b0;
    end
  endgenerate

  assign cls = classify(head);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;

  // Guard counter holds off busy sampling until the controller has seen the pulse.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)                 gcnt <= '0;
    else if (state == GUARD_WAIT) gcnt <= gcnt + GW'(1);
    else                          gcnt <= '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (pop) state_nx = ISSUE;
      ISSUE:      state_nx = (cls == CLS_DROP) ? IDLE : GUARD_WAIT;
      GUARD_WAIT: if (gcnt == GW'(GUARD - 1)) state_nx = BUSY_WAIT;
      BUSY_WAIT:  if (!i_busy) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    put_d = 1'b0;
    clr_d = 1'b0;
    if (state == ISSUE) begin
      put_d = (cls == CLS_PUT);
      clr_d = (cls == CLS_CLR);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_putchar   <= 1'b0;
      o_clearhome <= 1'b0;
      o_char      <= '0;
    end else begin
      o_putchar   <= put_d;
      o_clearhome <= clr_d;
      if (put_d) o_char <= head;
    end

endmodule

// File: tb/tb_uart_term_bridge.sv
// Directed bench for uart_term_bridge: latency, classification, backpressure,
// full buffer ordering, flush and mid-command reset.
module tb_uart_term_bridge;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tready;
  logic       flush, busy;
  logic       putchar, clearhome;
  logic [7:0] ch;
  logic [4:0] level;

  int n_pass = 0, n_tot = 0;
  int cyc = 0;
  int both_hi = 0;
  int ev_k[$], ev_c[$], ev_t[$];
  int a0;

  uart_term_bridge dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .i_flush(flush), .i_busy(busy),
    .o_putchar(putchar), .o_clearhome(clearhome), .o_char(ch), .o_level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log: kind 0 = putchar, 1 = clearhome
  always @(negedge clk) begin
    if (putchar && clearhome) both_hi++;
    if (putchar)   begin ev_k.push_back(0); ev_c.push_back(int'(ch)); ev_t.push_back(cyc); end
    if (clearhome) begin ev_k.push_back(1); ev_c.push_back(int'(ch)); ev_t.push_back(cyc); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ev_clr();
    ev_k.delete(); ev_c.delete(); ev_t.delete();
  endtask

  function automatic int ev_at(input int q, input int i);
    if (i >= ev_k.size()) return -1;
    case (q)
      0: return ev_k[i];
      1: return ev_c[i];
      default: return ev_t[i];
    endcase
  endfunction

  initial begin
    rst_n = 0; s_tdata = 0; s_tvalid = 0; m_tready = 0; flush = 0; busy = 0;
    repeat (3) step();
    chk("rst_put", putchar, 0);
    chk("rst_clr", clearhome, 0);
    chk("rst_char", ch, 0);
    chk("rst_lvl", level, 0);
    chk("rst_rdy", s_tready, 0);
    chk("rst_mvld", m_tvalid, 0);
    chk("rst_mdat", m_tdata, 0);
    rst_n = 1; #1;
    chk("rel_rdy0", s_tready, 0);
    step();
    chk("rel_rdy1", s_tready, 1);

    // 0x41: pulse two cycles after accept, echo held with tready low
    s_tdata = 8'h41; s_tvalid = 1;
    step(); s_tvalid = 0;
    chk("t1_lvl", level, 1);
    chk("t1_mvld", m_tvalid, 1);
    chk("t1_mdat", m_tdata, 8'h41);
    chk("t1_put0", putchar, 0);
    step();
    chk("t1_put1", putchar, 0);
    step();
    chk("t1_put2", putchar, 1);
    chk("t1_char", ch, 8'h41);
    step();
    chk("t1_put3", putchar, 0);

    // echo backpressure blocks accept; raising m_tready accepts same cycle
    chk("bp_rdy", s_tready, 0);
    ev_clr();
    s_tdata = 8'h0C; s_tvalid = 1;
    step();
    chk("bp_lvl", level, 0);
    m_tready = 1; #1;
    chk("bp_rdy_hi", s_tready, 1);
    step(); s_tvalid = 0;
    chk("bp_mdat", m_tdata, 8'h0C);
    chk("bp_mvld", m_tvalid, 1);
    step();
    chk("bp_mdrain", m_tvalid, 0);
    repeat (20) step();
    chk("clr_cnt", ev_k.size(), 1);
    chk("clr_kind", ev_at(0, 0), 1);
    chk("clr_char", ch, 8'h41);

    // 0x07 dropped, FSM back in IDLE one cycle after ISSUE
    ev_clr();
    s_tdata = 8'h07; s_tvalid = 1;
    step(); a0 = cyc;
    s_tdata = 8'h42;
    step(); s_tvalid = 0;
    repeat (15) step();
    chk("drop_cnt", ev_k.size(), 1);
    chk("drop_char", ev_at(1, 0), 8'h42);
    chk("drop_lat", ev_at(2, 0) - a0, 4);

    // fill buffer under busy, then drain in order
    busy = 1; ev_clr();
    for (int i = 0; i < 16; i++) begin
      s_tdata = 8'h30 + 8'(i); s_tvalid = 1;
      step();
    end
    s_tvalid = 0;
    chk("full_lvl", level, 16);
    chk("full_rdy", s_tready, 0);
    s_tdata = 8'h99; s_tvalid = 1;
    step(); s_tvalid = 0;
    chk("full_lvl2", level, 16);
    busy = 0;
    repeat (120) step();
    chk("drain_cnt", ev_k.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_c%0d", i), ev_at(1, i), 32'h30 + i);
      chk($sformatf("drain_k%0d", i), ev_at(0, i), 0);
      if (i > 0) chk($sformatf("drain_gap%0d", i), (ev_at(2, i) - ev_at(2, i-1)) >= 4, 1);
    end

    // flush while a command sits in BUSY_WAIT
    ev_clr();
    s_tdata = 8'h61; s_tvalid = 1;
    step(); s_tvalid = 0;
    step(); step();
    chk("fl_put", putchar, 1);
    busy = 1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = 8'h62 + 8'(i); s_tvalid = 1;
      step();
    end
    s_tvalid = 0;
    step();
    chk("fl_lvl4", level, 4);
    flush = 1; s_tdata = 8'h77; s_tvalid = 1; #1;
    chk("fl_rdy", s_tready, 0);
    step(); flush = 0; s_tvalid = 0;
    chk("fl_lvl0", level, 0);
    busy = 0;
    repeat (30) step();
    chk("fl_cnt", ev_k.size(), 1);
    chk("fl_char", ev_at(1, 0), 8'h61);
    ev_clr();
    s_tdata = 8'h66; s_tvalid = 1;
    step(); s_tvalid = 0;
    repeat (10) step();
    chk("fl_after", ev_at(1, 0), 8'h66);

    // reset during GUARD_WAIT
    ev_clr();
    s_tdata = 8'h52; s_tvalid = 1;
    step(); s_tdata = 8'h53;
    step(); s_tvalid = 0;
    step();
    chk("rg_put", putchar, 1);
    chk("rg_lvl", level, 1);
    #1 rst_n = 0; #1;
    chk("rg_put0", putchar, 0);
    chk("rg_char0", ch, 0);
    chk("rg_lvl0", level, 0);
    chk("rg_rdy0", s_tready, 0);
    chk("rg_mvld0", m_tvalid, 0);
    step(); rst_n = 1;
    ev_clr();
    repeat (20) step();
    chk("rg_cnt", ev_k.size(), 0);
    chk("rg_lvl", level, 0);

    chk("excl", both_hi, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
